// File: rtl/xc_malu_divrem_ctrl.sv
// Sequencer for the iterative divide/remainder step unit of the multi-cycle
// ALU. Accepts DIV/DIVU/REM/REMU, runs the external step unit, short-circuits
// divide-by-zero and signed overflow, applies sign fix-up and returns the
// 32-bit result on a valid/ready response port.
module xc_malu_divrem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              step_valid,
  output logic              step_signed,
  output logic              step_flush,
  output logic [XLEN-1:0]   step_rs1,
  output logic [XLEN-1:0]   step_rs2,
  output logic [5:0]        step_counter,
  output logic [2*XLEN-1:0] step_acc,
  output logic [XLEN-1:0]   step_arg0,
  output logic [XLEN-1:0]   step_arg1,
  input  logic [2*XLEN-1:0] step_n_acc,
  input  logic [XLEN-1:0]   step_n_arg0,
  input  logic [XLEN-1:0]   step_n_arg1,
  input  logic              step_finished
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [5:0]        counter_q, counter_d;
  logic              first_q, first_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   arg0_q, arg0_d;
  logic [XLEN-1:0]   arg1_q, arg1_d;
  logic [XLEN-1:0]   result_q, result_d;

  // op[0]=0 marks the signed forms (DIV, REM); op[1]=1 marks the remainder forms.
  logic req_signed, req_div0, req_ovf, lat_signed, neg_q, neg_r;
  logic [XLEN-1:0] fix_q, fix_r;

  // Request classification and sign fix-up of the captured step results.
  always_comb begin
    req_signed = ~req_op[0];
    req_div0   = (req_rs2 == '0);
    req_ovf    = req_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);
    lat_signed = ~op_q[0];
    neg_q      = lat_signed && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    neg_r      = lat_signed && rs1_q[XLEN-1];
    fix_q      = neg_q ? (~arg1_q + 1'b1) : arg1_q;
    fix_r      = neg_r ? (~arg0_q + 1'b1) : arg0_q;
  end

  // Next-state and datapath register updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    counter_d = counter_q;
    first_d   = first_q;
    acc_d     = acc_q;
    arg0_d    = arg0_q;
    arg1_d    = arg1_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d      = req_op;
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          counter_d = '0;
          first_d   = 1'b1;
          if (req_div0) begin
            result_d = req_op[1] ? req_rs1 : ALL_ONES;
            state_d  = S_RESP;
          end else if (req_ovf) begin
            result_d = req_op[1] ? '0 : INT_MIN;
            state_d  = S_RESP;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d  = step_n_acc;
        arg0_d = step_n_arg0;
        arg1_d = step_n_arg1;
        // The counter holds 0 through the first RUN cycle so the step unit
        // sees 0 on two consecutive cycles while it loads its operands.
        if (first_q) first_d = 1'b0;
        else         counter_d = counter_q + 6'd1;
        if (step_finished) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = op_q[1] ? fix_r : fix_q;
        state_d  = S_RESP;
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase

    // An abort beats everything, including a response handshake.
    if (flush) state_d = S_IDLE;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      counter_q <= '0;
      first_q   <= 1'b0;
      acc_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      counter_q <= counter_d;
      first_q   <= first_d;
      acc_q     <= acc_d;
      arg0_q    <= arg0_d;
      arg1_q    <= arg1_d;
      result_q  <= result_d;
    end
  end

  // Handshake and step-unit control outputs; reset forces the idle values.
  always_comb begin
    req_ready  = !resetn || ((state_q == S_IDLE) && !flush);
    rsp_valid  = resetn && (state_q == S_RESP);
    step_valid = resetn && (state_q == S_RUN);
    step_flush = !resetn || flush || (state_q == S_IDLE) ||
                 ((state_q == S_RESP) && rsp_ready);
  end

  assign rsp_result   = result_q;
  assign step_signed  = ~op_q[0];
  assign step_rs1     = rs1_q;
  assign step_rs2     = rs2_q;
  assign step_counter = counter_q;
  assign step_acc     = acc_q;
  assign step_arg0    = arg0_q;
  assign step_arg1    = arg1_q;

endmodule

// File: tb/tb_xc_malu_divrem_ctrl.sv
// Bench for xc_malu_divrem_ctrl: a behavioural step-unit stand-in plus a
// transaction-level model (cycles since accept, arithmetic result) checked
// against the DUT every cycle, with directed literal cases and random traffic.
module tb_xc_malu_divrem_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        step_valid, step_signed, step_flush;
  logic [31:0] step_rs1, step_rs2, step_arg0, step_arg1;
  logic [5:0]  step_counter;
  logic [63:0] step_acc;
  logic [63:0] step_n_acc;
  logic [31:0] step_n_arg0, step_n_arg1;
  logic        step_finished;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  xc_malu_divrem_ctrl dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .step_valid(step_valid), .step_signed(step_signed), .step_flush(step_flush),
    .step_rs1(step_rs1), .step_rs2(step_rs2), .step_counter(step_counter),
    .step_acc(step_acc), .step_arg0(step_arg0), .step_arg1(step_arg1),
    .step_n_acc(step_n_acc), .step_n_arg0(step_n_arg0), .step_n_arg1(step_n_arg1),
    .step_finished(step_finished)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a request, straight from the instruction semantics.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Transaction model: phase plus number of cycles since the accepting edge.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_RESP} m_phase_e;
  m_phase_e    m_phase = M_IDLE;
  int          m_cnt = 0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0, m_result = '0;
  logic [63:0] p_acc = '0, j_acc = '0;
  logic [31:0] p_arg0 = '0, p_arg1 = '0, j_arg0 = '0, j_arg1 = '0;

  // Step-unit stand-in: junk on every RUN cycle except the finishing one,
  // where it presents the unsigned magnitudes of quotient and remainder.
  logic [31:0] mag_a, mag_b, mag_q, mag_r;
  always_comb begin
    mag_a = (!m_op[0] && m_rs1[31]) ? -m_rs1 : m_rs1;
    mag_b = (!m_op[0] && m_rs2[31]) ? -m_rs2 : m_rs2;
    mag_q = (mag_b == 0) ? 32'h0 : mag_a / mag_b;
    mag_r = (mag_b == 0) ? 32'h0 : mag_a % mag_b;
    step_finished = (m_phase == M_BUSY) && (m_cnt == 34);
    step_n_acc    = j_acc;
    step_n_arg0   = step_finished ? mag_r : j_arg0;
    step_n_arg1   = step_finished ? mag_q : j_arg1;
  end

  // Model update on each rising edge from the inputs the bench applied.
  always @(posedge clock) begin
    if (m_phase == M_BUSY && m_cnt <= 34) begin
      p_acc  <= step_n_acc;
      p_arg0 <= step_n_arg0;
      p_arg1 <= step_n_arg1;
    end
    j_acc  <= {$urandom, $urandom};
    j_arg0 <= $urandom;
    j_arg1 <= $urandom;
    if (!resetn || flush) m_phase <= M_IDLE;
    else case (m_phase)
      M_IDLE: if (req_valid) begin
        m_op     <= req_op;
        m_rs1    <= req_rs1;
        m_rs2    <= req_rs2;
        m_cnt    <= 1;
        m_result <= ref_result(req_op, req_rs1, req_rs2);
        m_phase  <= is_special(req_op, req_rs1, req_rs2) ? M_RESP : M_BUSY;
      end
      M_BUSY: begin
        if (m_cnt == 35) m_phase <= M_RESP;
        m_cnt <= m_cnt + 1;
      end
      default: if (rsp_ready) m_phase <= M_IDLE;
    endcase
  end

  // Per-cycle comparison of every meaningful DUT output against the model.
  always @(negedge clock) begin
    if (!resetn) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_step_valid", step_valid, 0);
      check("rst_step_flush", step_flush, 1);
    end else case (m_phase)
      M_IDLE: begin
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_req_ready", req_ready, !flush);
        check("idle_step_valid", step_valid, 0);
        check("idle_step_flush", step_flush, 1);
      end
      M_BUSY: begin
        check("busy_rsp_valid", rsp_valid, 0);
        check("busy_req_ready", req_ready, 0);
        check("busy_step_flush", step_flush, flush);
        check("busy_step_valid", step_valid, m_cnt <= 34);
        check("busy_step_signed", step_signed, !m_op[0]);
        check("busy_step_rs1", step_rs1, m_rs1);
        check("busy_step_rs2", step_rs2, m_rs2);
        if (m_cnt <= 34)
          check("busy_counter", step_counter, (m_cnt <= 2) ? 0 : m_cnt - 2);
        if (m_cnt >= 2) begin
          check("busy_acc", step_acc, p_acc);
          check("busy_arg0", step_arg0, p_arg0);
          check("busy_arg1", step_arg1, p_arg1);
        end
      end
      default: begin
        check("resp_rsp_valid", rsp_valid, 1);
        check("resp_result", rsp_result, m_result);
        check("resp_req_ready", req_ready, 0);
        check("resp_step_valid", step_valid, 0);
        check("resp_step_flush", step_flush, flush || rsp_ready);
      end
    endcase
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; lat counts cycles after the accepting edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!rsp_valid && lat < 80);
    if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    rsp_ready = 1'b1;
    start(op, a, b);
    wait_rsp(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, rsp_result, exp);
    cyc();
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    logic [1:0] op;
    repeat (3) cyc();
    resetn = 1'b1;
    cyc();

    // Directed arithmetic with hand-computed results.
    run_op("divu_100_7", 2'd1, 100, 7, 14, 36);
    run_op("remu_100_7", 2'd3, 100, 7, 2, 36);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 36);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 36);
    run_op("rem_7_m2", 2'd2, 7, 32'hFFFF_FFFE, 1, 36);
    run_op("divu_5_0", 2'd1, 5, 0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", 2'd2, 5, 0, 5, 1);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    run_op("divu_big", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 36);

    // Back-pressure: result held stable while rsp_ready is low.
    rsp_ready = 1'b0;
    start(2'd1, 100, 7);
    wait_rsp(lat);
    check("hold_latency", lat, 36);
    repeat (10) begin
      @(negedge clock);
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, 14);
      check("hold_req_ready", req_ready, 0);
    end
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    cyc();
    check("hold_done_valid", rsp_valid, 0);
    check("hold_done_ready", req_ready, 1);

    // A request presented together with flush is refused.
    req_valid = 1'b1; flush = 1'b1; req_op = 2'd1; req_rs1 = 9; req_rs2 = 3;
    @(negedge clock);
    check("flush_idle_ready", req_ready, 0);
    @(posedge clock); #2;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("flush_idle_noacc", step_valid, 0);
    @(posedge clock); #2;

    // Flush at T+10 aborts; the next operation runs normally.
    start(2'd1, 100, 7);
    repeat (9) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (40) begin
      @(negedge clock);
      check("flush_no_rsp", rsp_valid, 0);
    end
    @(posedge clock); #2;
    run_op("after_flush", 2'd1, 9, 3, 3, 36);

    // Synchronous reset in the middle of RUN.
    start(2'd0, 1000, 7);
    repeat (5) cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    @(negedge clock);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_counter", step_counter, 0);
    check("rst_mid_step_valid", step_valid, 0);
    @(posedge clock); #2;

    // Random traffic with occasional aborts and response back-pressure.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom % 8)
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom % 200 - 100; b = $urandom % 20 - 10; end
        default: begin a = $urandom; b = $urandom >> ($urandom % 32); end
      endcase
      if ($urandom % 8 == 0) begin
        rsp_ready = 1'($urandom);
        start(op, a, b);
        repeat ($urandom_range(0, 40)) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        rsp_ready = 1'b1;
        cyc();
      end else begin
        rsp_ready = 1'b0;
        start(op, a, b);
        wait_rsp(lat);
        check("rand_result", rsp_result, ref_result(op, a, b));
        @(posedge clock); #2;
        repeat ($urandom % 4) cyc();
        rsp_ready = 1'b1;
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
